// File: rtl/gauss_pkg.sv
// ---------------------------------------------------------------------------
// gauss_pkg : shared defaults and sizing helpers for the CLT Gaussian path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gauss_pkg;

  localparam int W_IN_DEF    = 16;
  localparam int N_PAIRS_DEF = 6;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } gauss_state_e;

  // Sum of 2*n_pairs unsigned w_in-bit values plus a sign bit.
  function automatic int acc_w(input int w_in, input int n_pairs);
    return w_in + $clog2(2 * n_pairs) + 1;
  endfunction

  // Mean of the Irwin-Hall sum: n_pairs * 2^w_in.
  function automatic logic [63:0] offset(input int w_in, input int n_pairs);
    logic [63:0] v;
    v = 64'(unsigned'(n_pairs));
    return v << w_in;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clt_gaussian_accum.sv
// ---------------------------------------------------------------------------
// clt_gaussian_accum : sums 2*N_PAIRS uniforms and centres them into a
//                      signed Gaussian sample behind a valid/ready handshake
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clt_gaussian_accum
  import gauss_pkg::*;
#(
  parameter int W_IN    = W_IN_DEF,
  parameter int N_PAIRS = N_PAIRS_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic [31:0]                        u1,
  input  logic [31:0]                        u2,
  input  logic                               u_valid,
  output logic                               u_ready,
  output logic [acc_w(W_IN, N_PAIRS)-1:0]    noise,
  output logic                               noise_valid,
  input  logic                               noise_ready,
  output logic [31:0]                        sample_cnt
);

  localparam int                ACC_W     = acc_w(W_IN, N_PAIRS);
  localparam int                SUM_W     = ACC_W - 1;
  localparam int                BEAT_W    = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
  localparam logic [ACC_W-1:0]  OFFSET    = ACC_W'(offset(W_IN, N_PAIRS));
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_PAIRS - 1);

  logic [SUM_W-1:0]  r_acc;
  logic [BEAT_W-1:0] r_beat;
  logic [ACC_W-1:0]  r_noise;
  logic              r_noise_valid;
  logic [31:0]       r_sample_cnt;

  logic [W_IN-1:0]   w_a;
  logic [W_IN-1:0]   w_b;
  logic [SUM_W-1:0]  w_sum;
  logic [ACC_W-1:0]  w_sample;
  logic              w_accept;
  logic              w_last;
  logic              w_consume;
  gauss_state_e      w_state;
  logic              w_unused_lsbs;

  assign w_a = u1[31 -: W_IN];
  assign w_b = u2[31 -: W_IN];
  // Only the MSBs feed the sum; the rest of each word is intentionally dropped.
  assign w_unused_lsbs = ^{u1, u2};

  assign w_sum    = r_acc + SUM_W'(w_a) + SUM_W'(w_b);
  assign w_sample = {1'b0, w_sum} - OFFSET;

  // HOLD means a finished sample is blocked; beats and acc freeze there.
  assign w_state   = (r_noise_valid && !noise_ready) ? HOLD : ACCUM;
  assign u_ready   = (w_state == ACCUM);
  assign w_accept  = u_valid && u_ready;
  assign w_last    = (r_beat == LAST_BEAT);
  assign w_consume = r_noise_valid && noise_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc         <= '0;
      r_beat        <= '0;
      r_noise       <= '0;
      r_noise_valid <= 1'b0;
      r_sample_cnt  <= '0;
    end else if (clear) begin
      r_acc         <= '0;
      r_beat        <= '0;
      r_noise_valid <= 1'b0;
    end else begin
      if (w_accept && w_last) begin
        r_noise       <= w_sample;
        r_noise_valid <= 1'b1;
        r_acc         <= '0;
        r_beat        <= '0;
      end else begin
        if (w_accept) begin
          r_acc  <= w_sum;
          r_beat <= r_beat + 1'b1;
        end
        if (w_consume) begin
          r_noise_valid <= 1'b0;
        end
      end
      if (w_consume) begin
        r_sample_cnt <= r_sample_cnt + 32'd1;
      end
    end
  end

  assign noise       = r_noise;
  assign noise_valid = r_noise_valid;
  assign sample_cnt  = r_sample_cnt;

endmodule

`default_nettype wire

// File: tb/tb_clt_gaussian_accum.sv
// ---------------------------------------------------------------------------
// tb_clt_gaussian_accum : directed checks of the CLT Gaussian accumulator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_clt_gaussian_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [31:0] u1, u2;
  logic        u_valid;
  logic        u_ready;
  logic [20:0] noise;
  logic        noise_valid;
  logic        noise_ready;
  logic [31:0] sample_cnt;

  // Second instance with N_PAIRS=1 so completion can coincide with consumption.
  logic        d1_clear;
  logic [31:0] d1_u1, d1_u2;
  logic        d1_u_valid;
  logic        d1_u_ready;
  logic [5:0]  d1_noise;
  logic        d1_noise_valid;
  logic        d1_noise_ready;
  logic [31:0] d1_sample_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  clt_gaussian_accum u_dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .u1          (u1),
    .u2          (u2),
    .u_valid     (u_valid),
    .u_ready     (u_ready),
    .noise       (noise),
    .noise_valid (noise_valid),
    .noise_ready (noise_ready),
    .sample_cnt  (sample_cnt)
  );

  clt_gaussian_accum #(.W_IN(4), .N_PAIRS(1)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .clear       (d1_clear),
    .u1          (d1_u1),
    .u2          (d1_u2),
    .u_valid     (d1_u_valid),
    .u_ready     (d1_u_ready),
    .noise       (d1_noise),
    .noise_valid (d1_noise_valid),
    .noise_ready (d1_noise_ready),
    .sample_cnt  (d1_sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b);
    u1      = a;
    u2      = b;
    u_valid = 1'b1;
    step();
    u_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    clear          = 1'b0;
    u_valid        = 1'b0;
    u1             = '0;
    u2             = '0;
    noise_ready    = 1'b1;
    d1_clear       = 1'b0;
    d1_u_valid     = 1'b0;
    d1_u1          = '0;
    d1_u2          = '0;
    d1_noise_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst            = 1'b0;
    clear          = 1'b0;
    u_valid        = 1'b0;
    u1             = '0;
    u2             = '0;
    noise_ready    = 1'b1;
    d1_clear       = 1'b0;
    d1_u_valid     = 1'b0;
    d1_u1          = '0;
    d1_u2          = '0;
    d1_noise_ready = 1'b0;
    #2;
    check("rst_noise", 64'(noise), 64'h0);
    check("rst_nv", 64'(noise_valid), 64'h0);
    check("rst_cnt", 64'(sample_cnt), 64'h0);
    check("rst_uready", 64'(u_ready), 64'h1);
    step();
    step();
    rst = 1'b1;

    // All-zero inputs: most negative sample
    repeat (6) beat(32'h0, 32'h0);
    check("zero_nv", 64'(noise_valid), 64'h1);
    check("zero_noise", 64'(noise), 64'h1A0000);
    step();
    check("zero_nv_drop", 64'(noise_valid), 64'h0);
    check("zero_cnt", 64'(sample_cnt), 64'h1);

    // All-ones inputs: most positive sample
    repeat (6) beat(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("ones_noise", 64'(noise), 64'h05FFF4);
    step();
    check("ones_cnt", 64'(sample_cnt), 64'h2);

    // Midscale, three samples back-to-back
    do_reset();
    for (int i = 0; i < 18; i++) begin
      beat(32'h8000_0000, 32'h8000_0000);
      check("b2b_nv", 64'(noise_valid), 64'((i % 6) == 5));
      if ((i % 6) == 5) check("b2b_noise", 64'(noise), 64'h0);
    end
    step();
    check("b2b_cnt", 64'(sample_cnt), 64'h3);
    check("b2b_nv_end", 64'(noise_valid), 64'h0);

    // Backpressure: 6*(0x1234+0x5678) - 393216 = -232440
    do_reset();
    noise_ready = 1'b0;
    repeat (6) beat(32'h1234_0000, 32'h5678_0000);
    check("bp_nv", 64'(noise_valid), 64'h1);
    check("bp_noise", 64'(noise), 64'h1C7408);
    check("bp_uready", 64'(u_ready), 64'h0);
    u1      = 32'h8000_0000;
    u2      = 32'h8000_0000;
    u_valid = 1'b1;
    repeat (10) begin
      step();
      check("bp_hold_noise", 64'(noise), 64'h1C7408);
      check("bp_hold_nv", 64'(noise_valid), 64'h1);
      check("bp_hold_uready", 64'(u_ready), 64'h0);
    end
    noise_ready = 1'b1;
    #1;
    check("bp_release_uready", 64'(u_ready), 64'h1);
    step();
    check("bp_consumed_nv", 64'(noise_valid), 64'h0);
    check("bp_consumed_cnt", 64'(sample_cnt), 64'h1);
    repeat (5) beat(32'h8000_0000, 32'h8000_0000);
    check("bp_next_nv", 64'(noise_valid), 64'h1);
    check("bp_next_noise", 64'(noise), 64'h0);
    step();
    check("bp_next_cnt", 64'(sample_cnt), 64'h2);

    // clear mid-accumulation discards partial sum and the pair presented with it
    do_reset();
    repeat (3) beat(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    clear   = 1'b1;
    u1      = 32'hFFFF_FFFF;
    u2      = 32'hFFFF_FFFF;
    u_valid = 1'b1;
    step();
    clear   = 1'b0;
    u_valid = 1'b0;
    check("clr_nv", 64'(noise_valid), 64'h0);
    check("clr_cnt", 64'(sample_cnt), 64'h0);
    repeat (6) beat(32'h8000_0000, 32'h8000_0000);
    check("clr_after_nv", 64'(noise_valid), 64'h1);
    check("clr_after_noise", 64'(noise), 64'h0);
    step();
    check("clr_after_cnt", 64'(sample_cnt), 64'h1);

    // async reset mid-accumulation
    repeat (6) beat(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("ar_pre_noise", 64'(noise), 64'h05FFF4);
    step();
    check("ar_pre_cnt", 64'(sample_cnt), 64'h2);
    repeat (3) beat(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #3;
    rst = 1'b0;
    #1;
    check("ar_cnt", 64'(sample_cnt), 64'h0);
    check("ar_nv", 64'(noise_valid), 64'h0);
    check("ar_noise", 64'(noise), 64'h0);
    check("ar_uready", 64'(u_ready), 64'h1);
    rst = 1'b1;
    step();
    repeat (6) beat(32'h8000_0000, 32'h8000_0000);
    check("ar_after_nv", 64'(noise_valid), 64'h1);
    check("ar_after_noise", 64'(noise), 64'h0);
    step();
    check("ar_after_cnt", 64'(sample_cnt), 64'h1);

    // clear on the completing beat wins over completion
    do_reset();
    repeat (5) beat(32'h8000_0000, 32'h8000_0000);
    clear = 1'b1;
    beat(32'h8000_0000, 32'h8000_0000);
    clear = 1'b0;
    check("clrc_nv", 64'(noise_valid), 64'h0);
    check("clrc_cnt", 64'(sample_cnt), 64'h0);
    repeat (6) beat(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("clrc_after_noise", 64'(noise), 64'h05FFF4);

    // N_PAIRS=1, W_IN=4 (OFFSET=16): completion coinciding with consumption
    do_reset();
    d1_noise_ready = 1'b1;
    d1_u_valid     = 1'b1;
    d1_u1          = 32'hF000_0000;
    d1_u2          = 32'h1000_0000;
    step();
    check("d1_first_nv", 64'(d1_noise_valid), 64'h1);
    check("d1_first_noise", 64'(d1_noise), 64'h00);
    check("d1_first_cnt", 64'(d1_sample_cnt), 64'h0);
    d1_u1 = 32'hFFFF_FFFF;
    d1_u2 = 32'hFFFF_FFFF;
    step();
    check("d1_coinc_nv", 64'(d1_noise_valid), 64'h1);
    check("d1_coinc_noise", 64'(d1_noise), 64'h0E);
    check("d1_coinc_cnt", 64'(d1_sample_cnt), 64'h1);
    d1_u1 = 32'h0;
    d1_u2 = 32'h0;
    step();
    check("d1_coinc2_noise", 64'(d1_noise), 64'h30);
    check("d1_coinc2_cnt", 64'(d1_sample_cnt), 64'h2);
    d1_clear = 1'b1;
    d1_u1    = 32'hFFFF_FFFF;
    step();
    check("d1_clr_nv", 64'(d1_noise_valid), 64'h0);
    check("d1_clr_cnt", 64'(d1_sample_cnt), 64'h2);
    check("d1_clr_noise", 64'(d1_noise), 64'h30);
    d1_clear   = 1'b0;
    d1_u_valid = 1'b0;
    step();
    check("d1_idle_nv", 64'(d1_noise_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
